alu_seq: RTL

//  Execute-stage sequencer for the cpu2 ALU. Accepts one decoded ALU instruction per handshake,

---
 rtl/alu_seq.sv | 121 ++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Execute-stage sequencer for the cpu2 ALU: registers one decoded op per handshake,
// waits out the multiply latency, then commits result and flags to the write port.
module alu_seq #(
  parameter int          WIDTH     = 32,
  parameter int          IWIDTH    = 16,
  parameter int          RADDR     = 4,
  parameter int          MUL_LAT   = 3,
  parameter logic [7:0]  FLAGS_RST = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_op,
  input  logic [RADDR-1:0]  req_rd,
  input  logic [WIDTH-1:0]  req_bi,
  input  logic [WIDTH-1:0]  req_di,
  input  logic [IWIDTH-1:0] req_im,
  input  logic              flush,
  output logic [5:0]        alu_op,
  output logic [7:0]        alu_fi,
  output logic [WIDTH-1:0]  alu_bi,
  output logic [WIDTH-1:0]  alu_di,
  output logic [IWIDTH-1:0] alu_im,
  input  logic [WIDTH-1:0]  alu_res,
  input  logic [7:0]        alu_fo,
  input  logic              alu_wb_en,
  input  logic              alu_flag_en,
  output logic              wb_valid,
  output logic [RADDR-1:0]  wb_addr,
  output logic [WIDTH-1:0]  wb_data,
  output logic [7:0]        flags,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, MULW, WB} state_t;

  localparam bit         HAS_MUL_WAIT = (MUL_LAT > 0);
  // Counter runs MUL_LAT-1 .. 0 so the commit lands on the last wait cycle.
  localparam logic [3:0] CNT_INIT     = HAS_MUL_WAIT ? 4'(MUL_LAT - 1) : 4'd0;

  state_t           state, state_nxt;
  logic             accept, is_mul, commit, load_cnt;
  logic [3:0]       cnt;
  logic [RADDR-1:0] rd_q;

  assign is_mul = !alu_op[5] && (alu_op[3:0] == 4'h9);
  assign alu_fi = flags;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = EXEC;
      EXEC: begin
        if (flush)                       state_nxt = IDLE;
        else if (is_mul && HAS_MUL_WAIT) state_nxt = MULW;
        else                             state_nxt = WB;
      end
      MULW: begin
        if (flush)          state_nxt = IDLE;
        else if (cnt == '0) state_nxt = WB;
      end
      WB:      state_nxt = accept ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Flush wins over both accept and commit in the cycle it is asserted.
  always_comb begin
    req_ready = ((state == IDLE) || (state == WB)) && !flush;
    accept    = req_valid && req_ready;
    busy      = (state != IDLE);
    load_cnt  = !flush && (state == EXEC) && is_mul && HAS_MUL_WAIT;
    commit    = !flush && (((state == EXEC) && !(is_mul && HAS_MUL_WAIT)) ||
                           ((state == MULW) && (cnt == '0)));
  end

  // Operands are only reloaded on accept, so they stay stable through MULW and IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_op <= '0;
      rd_q   <= '0;
      alu_bi <= '0;
      alu_di <= '0;
      alu_im <= '0;
      cnt    <= '0;
    end else begin
      if (accept) begin
        alu_op <= req_op;
        rd_q   <= req_rd;
        alu_bi <= req_bi;
        alu_di <= req_di;
        alu_im <= req_im;
      end
      if (load_cnt)                          cnt <= CNT_INIT;
      else if ((state == MULW) && cnt != '0) cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      flags    <= FLAGS_RST;
    end else begin
      wb_valid <= commit && alu_wb_en;
      if (commit) begin
        wb_data <= alu_res;
        wb_addr <= rd_q;
        if (alu_flag_en) flags <= alu_fo;
      end
    end
  end

endmodule
